// File: rtl/vga_layer_ram.sv
// vga_layer_ram
// Two-plane display memory: a DATA_W-bit canvas plane and a 1-bit mask plane.
// Each plane has its own write port. The block also holds a clear engine
// that sweeps both planes, and a two-stage display pipeline that down-scales
// VGA coordinates per plane and overlays the mask on the canvas.
//
// Ports
//   clk_i, rst_ni                      system clock, async active-low reset
//   disp_en_i, disp_x_i, disp_y_i      display fetch request and coordinate
//   c_we_i, c_x_i, c_y_i, c_data_i     canvas write port
//   m_we_i, m_x_i, m_y_i, m_data_i     mask write port
//   m_rd_x_i, m_rd_y_i, m_rd_data_o    mask random read, 1-cycle latency
//   clr_start_i, clr_busy_o, clr_done_o  clear engine control and status
//   pix_out_o, pix_valid_o, is_mask_o  composed display pixel, 2-cycle latency
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | normal operation, port writes accepted, waits for clr_start_i
//   ST_CLEAR | sweeping both planes, port writes and clr_start_i dropped
module vga_layer_ram #(
    parameter int                 DATA_W     = 9,
    parameter int                 CX_W       = 8,
    parameter int                 CY_W       = 7,
    parameter int                 MX_W       = 9,
    parameter int                 MY_W       = 8,
    parameter int                 C_SHIFT    = 2,
    parameter int                 M_SHIFT    = 1,
    parameter int                 X_W        = 10,
    parameter int                 Y_W        = 9,
    parameter logic [DATA_W-1:0]  CLEAR_VAL  = '0,
    parameter logic [DATA_W-1:0]  MASK_COLOR = 9'h1FF,
    parameter bit                 OVERLAY_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              disp_en_i,
    input  logic [X_W-1:0]    disp_x_i,
    input  logic [Y_W-1:0]    disp_y_i,
    input  logic              c_we_i,
    input  logic [CX_W-1:0]   c_x_i,
    input  logic [CY_W-1:0]   c_y_i,
    input  logic [DATA_W-1:0] c_data_i,
    input  logic              m_we_i,
    input  logic [MX_W-1:0]   m_x_i,
    input  logic [MY_W-1:0]   m_y_i,
    input  logic              m_data_i,
    input  logic [MX_W-1:0]   m_rd_x_i,
    input  logic [MY_W-1:0]   m_rd_y_i,
    output logic              m_rd_data_o,
    input  logic              clr_start_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic [DATA_W-1:0] pix_out_o,
    output logic              pix_valid_o,
    output logic              is_mask_o
);

    localparam int CA_W    = CX_W + CY_W;
    localparam int MA_W    = MX_W + MY_W;
    localparam int CNT_W   = (CA_W > MA_W) ? CA_W : MA_W;
    localparam int C_DEPTH = 1 << CA_W;
    localparam int M_DEPTH = 1 << MA_W;

    // Depths widened by one bit so the in-range compare also works when a
    // plane is exactly as deep as the sweep.
    localparam logic [CNT_W:0] C_LIMIT = (CNT_W+1)'(C_DEPTH);
    localparam logic [CNT_W:0] M_LIMIT = (CNT_W+1)'(M_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    logic [DATA_W-1:0] canvas_mem [C_DEPTH];
    logic              mask_mem   [M_DEPTH];

    state_e            state_q;
    logic [CNT_W-1:0]  clr_cnt_q;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic              disp_vld_q;
    logic [DATA_W-1:0] c_rd_q;
    logic              m_disp_rd_q;
    logic [DATA_W-1:0] pix_out_q;
    logic              pix_valid_q;
    logic              is_mask_q;
    logic              m_rd_data_q;

    logic              clearing;
    logic              c_wr_en_d;
    logic [CA_W-1:0]   c_wr_addr_d;
    logic [DATA_W-1:0] c_wr_data_d;
    logic              m_wr_en_d;
    logic [MA_W-1:0]   m_wr_addr_d;
    logic              m_wr_data_d;
    logic [CA_W-1:0]   c_disp_addr_d;
    logic [MA_W-1:0]   m_disp_addr_d;
    logic [MA_W-1:0]   m_rd_addr_d;

    assign clearing = (state_q == ST_CLEAR);

    // Display coordinates are scaled per plane, then truncated so that
    // out-of-range positions simply wrap.
    assign c_disp_addr_d = {CY_W'(disp_y_i >> C_SHIFT), CX_W'(disp_x_i >> C_SHIFT)};
    assign m_disp_addr_d = {MY_W'(disp_y_i >> M_SHIFT), MX_W'(disp_x_i >> M_SHIFT)};
    assign m_rd_addr_d   = {m_rd_y_i, m_rd_x_i};

    // The sweep owns both write ports while clearing; the smaller plane is
    // left alone once the counter runs past its depth.
    always_comb begin
        c_wr_en_d   = c_we_i;
        c_wr_addr_d = {c_y_i, c_x_i};
        c_wr_data_d = c_data_i;
        m_wr_en_d   = m_we_i;
        m_wr_addr_d = {m_y_i, m_x_i};
        m_wr_data_d = m_data_i;
        if (clearing) begin
            c_wr_en_d   = ({1'b0, clr_cnt_q} < C_LIMIT);
            c_wr_addr_d = CA_W'(clr_cnt_q);
            c_wr_data_d = CLEAR_VAL;
            m_wr_en_d   = ({1'b0, clr_cnt_q} < M_LIMIT);
            m_wr_addr_d = MA_W'(clr_cnt_q);
            m_wr_data_d = 1'b0;
        end
    end

    // Memory arrays and the first pipeline stage carry no reset so they map
    // onto block RAM; reads see the value from before a same-cycle write.
    always_ff @(posedge clk_i) begin
        if (c_wr_en_d) begin
            canvas_mem[c_wr_addr_d] <= c_wr_data_d;
        end
        if (m_wr_en_d) begin
            mask_mem[m_wr_addr_d] <= m_wr_data_d;
        end
        c_rd_q      <= canvas_mem[c_disp_addr_d];
        m_disp_rd_q <= mask_mem[m_disp_addr_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_vld_q  <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            is_mask_q   <= 1'b0;
            m_rd_data_q <= 1'b0;
        end else begin
            disp_vld_q  <= disp_en_i;
            m_rd_data_q <= mask_mem[m_rd_addr_d];
            pix_valid_q <= disp_vld_q;
            is_mask_q   <= disp_vld_q & m_disp_rd_q;
            if (!disp_vld_q) begin
                pix_out_q <= '0;
            end else if (OVERLAY_EN && m_disp_rd_q) begin
                pix_out_q <= MASK_COLOR;
            end else begin
                pix_out_q <= c_rd_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_start_i) begin
                        state_q    <= ST_CLEAR;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    // Sweep length is a power of two, so the last word is all ones.
                    if (&clr_cnt_q) begin
                        state_q    <= ST_IDLE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_out_o   = pix_out_q;
    assign pix_valid_o = pix_valid_q;
    assign is_mask_o   = is_mask_q;
    assign m_rd_data_o = m_rd_data_q;
    assign clr_busy_o  = clr_busy_q;
    assign clr_done_o  = clr_done_q;

endmodule

// File: doc/vga_layer_ram.md
# vga_layer_ram

Parametrised two-plane display memory for the camera/VGA path: a multi-bit canvas plane and a 1-bit mask plane (finger map). Each plane has its own write port. The block adds a hardware clear engine and a registered display pipeline that down-scales VGA pixel coordinates per plane and overlays the mask on the canvas. It sits between the image-processing writers and the VGA timing generator, and all activity is on the single system clock.

## Interface
- DATA_W, 9, canvas pixel width
- CX_W / CY_W, 8 / 7, canvas column/row address bits; canvas depth 2^(CX_W+CY_W)
- MX_W / MY_W, 9 / 8, mask column/row address bits; mask depth 2^(MX_W+MY_W)
- C_SHIFT / M_SHIFT, 2 / 1, right-shift from display coordinate to canvas/mask coordinate
- X_W / Y_W, 10 / 9, display coordinate widths
- CLEAR_VAL, 0, canvas value written by the clear engine
- MASK_COLOR, 9'h1FF, pixel emitted where the mask bit is 1 and overlay is enabled
- OVERLAY_EN, 1, 1 = mask overrides canvas on pix_out
---
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- disp_en  in  1  display fetch request this cycle
- disp_x / disp_y  in  X_W / Y_W  display pixel coordinate
- c_we  in  1  canvas write enable
- c_x / c_y  in  CX_W / CY_W  canvas write coordinate
- c_data  in  DATA_W  canvas write data
- m_we  in  1  mask write enable
- m_x / m_y  in  MX_W / MY_W  mask write coordinate
- m_data  in  1  mask write data
- m_rd_x / m_rd_y  in  MX_W / MY_W  mask random-read coordinate
- m_rd_data  out  1  mask random-read result
- clr_start  in  1  start a clear sweep (sampled in IDLE only)
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse at the end of the sweep
- pix_out  out  DATA_W  composed display pixel
- pix_valid  out  1  pix_out corresponds to an accepted disp_en
- is_mask  out  1  mask bit at the display pixel

## Operation
- Canvas address = {c_y, c_x}. Mask address = {m_y, m_x}.
- Display lookup:
  - canvas coordinate = {disp_y>>C_SHIFT, disp_x>>C_SHIFT}, each truncated to CY_W/CX_W.
  - mask coordinate = {disp_y>>M_SHIFT, disp_x>>M_SHIFT}, each truncated to MY_W/MX_W.
  - Out-of-range coordinates wrap through truncation; there is no error flag.
- Composition: if OVERLAY_EN and mask bit = 1, pix_out = MASK_COLOR; otherwise pix_out = canvas word. If disp_en was 0, pix_out = 0 and pix_valid = 0.
- Writes are synchronous. A read of the address written in the same cycle returns the old data (read-before-write).
- Clear FSM, IDLE -> CLEAR -> IDLE:
  - IDLE: clr_start = 1 -> CLEAR, with the counter cleared to 0.
  - CLEAR: each cycle, write CLEAR_VAL to canvas[cnt] if cnt < canvas depth, and write 0 to mask[cnt] if cnt < mask depth. The counter increments each cycle.
  - At cnt = max(depths) - 1: go to IDLE and pulse clr_done for one cycle.
  - clr_busy = 1 exactly while in CLEAR.
- During CLEAR, c_we and m_we are ignored (writes are dropped) and clr_start is ignored. Display reads and mask random reads continue and return the current contents.
- c_we or m_we asserted in the same cycle as an accepted clr_start in IDLE is performed; the sweep then overwrites it.
- Reset:
  - Asserting rst returns the FSM to IDLE and clears the counter and all output registers.
  - Memory contents are not reset. A sweep interrupted by reset leaves memory partially cleared.

## Timing
- Reset values: pix_out = 0, pix_valid = 0, is_mask = 0, m_rd_data = 0, clr_busy = 0, clr_done = 0.
- Display latency is 2 cycles: RAM read registered at edge N+1, composition registered at edge N+2. The pipeline accepts one request per cycle with no stalls.
- m_rd_data latency is 1 cycle.
- clr_busy rises on the edge after an accepted clr_start.
- A clear sweep lasts max(2^(CX_W+CY_W), 2^(MX_W+MY_W)) cycles; with defaults this is 131072 cycles.
- clr_done is high for the single cycle after the last write; clr_busy is 0 in that same cycle.

## Test plan
- Reset: hold rst = 0, then release it. All outputs are 0; clr_busy stays 0 with no clr_start.
- Canvas write and display: write c_x = 5, c_y = 3, c_data = 9'h0A5. Drive disp_en = 1, disp_x = 20..23, disp_y = 12..15. pix_out = 9'h0A5 with pix_valid = 1 two cycles after each request; a neighbouring pixel returns its own value.
- Overlay: write mask bit at m_x = 10, m_y = 6. Display at disp_x = 20, disp_y = 12 gives is_mask = 1 and pix_out = 9'h1FF. With OVERLAY_EN = 0, the same request gives pix_out = 9'h0A5.
- Clear (reduced params CX_W = CY_W = MX_W = MY_W = 2):
  - Pulse clr_start: clr_busy = 1 for 16 cycles, then clr_done pulses once.
  - A c_we issued mid-sweep is lost.
  - All canvas words read CLEAR_VAL and all mask bits read 0.
- Same-cycle events:
  - c_we together with an accepted clr_start: the word ends cleared.
  - clr_start while busy: no restart, and the sweep length is unchanged.
  - Write and read of the same address in one cycle: the old value is returned.
- Reset mid-clear: assert rst at sweep cycle 7 of 16. clr_busy drops immediately with no clr_done. Words 0..6 are cleared and the remaining words keep their prior data.
